// File: rtl/fifo_drain_serializer.sv
// Pops words from a FWFT FIFO and emits them as RATIO OUT_WIDTH-bit slices, LSB slice first.
// Latency: one cycle from pop to first valid slice; back-to-back words stream without bubbles.
// Backpressure: slices hold stable while m_ready is low; no pop happens until the held word's last slice is accepted.
module fifo_drain_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int SCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SCW-1:0] LAST_SLICE = SCW'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [SCW-1:0]        slice_cnt;
    logic                  accept;
    logic                  final_accept;

    assign accept       = m_valid & m_ready;
    assign final_accept = accept & (slice_cnt == LAST_SLICE);
    // Gated by rst_n so a non-empty FIFO is never popped while the block is held in reset.
    assign fifo_rd_en   = rst_n & ~fifo_empty & ((state == IDLE) | final_accept);
    assign m_data       = shift_reg[OUT_WIDTH-1:0];
    assign busy         = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            slice_cnt  <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            word_count <= '0;
        end else begin
            if (final_accept) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end

            if (fifo_rd_en) begin
                state     <= SEND;
                shift_reg <= fifo_rd_data;
                slice_cnt <= '0;
                m_valid   <= 1'b1;
                m_last    <= 1'b0;
            end else if (final_accept) begin
                state     <= IDLE;
                shift_reg <= '0;
                slice_cnt <= '0;
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
            end else if (accept) begin
                shift_reg <= shift_reg >> OUT_WIDTH;
                slice_cnt <= slice_cnt + SCW'(1);
                m_last    <= ((slice_cnt + SCW'(1)) == LAST_SLICE);
            end
        end
    end

endmodule
